// File: rtl/la_capture_sequencer_if.sv
// Byte stream from the capture sequencer toward the host link.
// master drives samples, slave (UART/FIFO side) drives ready.
interface la_capture_sequencer_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_last;

  modport master (output m_valid, output m_data, output m_last, input m_ready);
  modport slave  (input m_valid, input m_data, input m_last, output m_ready);
endinterface

// File: rtl/la_capture_sequencer.sv
// Sequences one capture of logic_analyzer_core: arm the core, wait for the
// capture to finish, then read the circular buffer back oldest-sample-first
// onto a valid/ready stream while the core is held disabled.
module la_capture_sequencer #(
  parameter int DATA_WIDTH           = 8,
  parameter int ADDR_WIDTH           = 11,
  parameter int POST_TRIGGER_SAMPLES = (1 << ADDR_WIDTH) / 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  arm,
  input  logic                  abort,
  output logic                  trigger_enable,
  input  logic                  core_capture_done,
  input  logic                  core_triggered,
  input  logic [ADDR_WIDTH-1:0] core_trigger_index,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  la_capture_sequencer_if.master m,
  output logic                  busy,
  output logic [1:0]            seq_state,
  output logic                  dump_done
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_READOUT = 2'd2,
    S_FLUSH   = 2'd3
  } state_t;

  // Oldest sample sits just past the post-trigger window (wraps naturally).
  localparam logic [ADDR_WIDTH-1:0] START_OFFSET = ADDR_WIDTH'(POST_TRIGGER_SAMPLES + 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH        = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]   ONE_BEAT     = (ADDR_WIDTH+1)'(1);

  state_t                  state_reg;
  logic                    trigger_enable_reg;
  logic                    dump_done_reg;
  logic [ADDR_WIDTH-1:0]   start_addr_reg;
  logic [ADDR_WIDTH-1:0]   rd_cnt_reg;
  logic [ADDR_WIDTH:0]     remaining_reg;
  logic                    rd_pend_reg;
  logic                    out_valid_reg;
  logic [DATA_WIDTH-1:0]   out_data_reg;
  logic                    spare_valid_reg;
  logic [DATA_WIDTH-1:0]   spare_data_reg;

  logic                    pop;
  logic                    issue;
  logic [1:0]              occ;
  logic                    status_unused;

  // core_triggered is informational only; the sequencer never times out.
  assign status_unused = core_triggered;

  assign pop = out_valid_reg & m.m_ready;
  // Buffer entries held plus the read whose data is on rd_data this cycle.
  assign occ = 2'(out_valid_reg) + 2'(spare_valid_reg) + 2'(rd_pend_reg);
  // A beat leaving this cycle frees a slot in time for a read issued now,
  // which is what keeps the two-entry buffer at one beat per cycle.
  assign issue = (state_reg == S_READOUT) &&
                 ((occ < 2'd2) || (pop && (occ == 2'd2)));

  assign rd_en          = issue;
  assign rd_addr        = start_addr_reg + rd_cnt_reg;
  assign m.m_valid      = out_valid_reg;
  assign m.m_data       = out_data_reg;
  assign m.m_last       = out_valid_reg && (remaining_reg == ONE_BEAT);
  assign trigger_enable = trigger_enable_reg;
  assign dump_done      = dump_done_reg;
  assign busy           = (state_reg != S_IDLE);
  assign seq_state      = state_reg;

  // Two-entry output buffer (output register + spare) fed by BRAM reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend_reg     <= 1'b0;
      out_valid_reg   <= 1'b0;
      out_data_reg    <= '0;
      spare_valid_reg <= 1'b0;
      spare_data_reg  <= '0;
    end else if (abort) begin
      rd_pend_reg     <= 1'b0;
      out_valid_reg   <= 1'b0;
      spare_valid_reg <= 1'b0;
    end else begin
      rd_pend_reg <= issue;
      if (!out_valid_reg || pop) begin
        if (spare_valid_reg) begin
          out_valid_reg   <= 1'b1;
          out_data_reg    <= spare_data_reg;
          spare_valid_reg <= rd_pend_reg;
          if (rd_pend_reg) begin
            spare_data_reg <= rd_data;
          end
        end else begin
          out_valid_reg <= rd_pend_reg;
          if (rd_pend_reg) begin
            out_data_reg <= rd_data;
          end
        end
      end else if (rd_pend_reg) begin
        spare_valid_reg <= 1'b1;
        spare_data_reg  <= rd_data;
      end
    end
  end

  // Capture-cycle FSM: arm, wait for capture, issue reads, drain, finish.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg          <= S_IDLE;
      trigger_enable_reg <= 1'b0;
      dump_done_reg      <= 1'b0;
      start_addr_reg     <= '0;
      rd_cnt_reg         <= '0;
      remaining_reg      <= '0;
    end else begin
      dump_done_reg <= 1'b0;
      if (abort) begin
        state_reg          <= S_IDLE;
        trigger_enable_reg <= 1'b0;
      end else begin
        if (pop) begin
          remaining_reg <= remaining_reg - ONE_BEAT;
        end
        case (state_reg)
          S_IDLE: begin
            if (arm) begin
              state_reg          <= S_ARMED;
              trigger_enable_reg <= 1'b1;
            end
          end
          S_ARMED: begin
            if (core_capture_done) begin
              start_addr_reg     <= core_trigger_index + START_OFFSET;
              rd_cnt_reg         <= '0;
              remaining_reg      <= DEPTH;
              trigger_enable_reg <= 1'b0;
              state_reg          <= S_READOUT;
            end
          end
          S_READOUT: begin
            if (issue) begin
              rd_cnt_reg <= rd_cnt_reg + ADDR_WIDTH'(1);
              if (rd_cnt_reg == {ADDR_WIDTH{1'b1}}) begin
                state_reg <= S_FLUSH;
              end
            end
          end
          S_FLUSH: begin
            if (pop && (remaining_reg == ONE_BEAT)) begin
              dump_done_reg <= 1'b1;
              state_reg     <= S_IDLE;
            end
          end
          default: state_reg <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_la_capture_sequencer.sv
// Scoreboard bench for la_capture_sequencer with a 16-deep buffer model
// preloaded mem[i] = i. Stimulus pushes expected beats/addresses; a monitor
// pops and compares whenever the DUT reads or hands over a beat.
module tb_la_capture_sequencer;
  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int PTS   = 8;

  typedef struct {
    logic [DW-1:0] d;
    logic          l;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          arm = 1'b0;
  logic          abort = 1'b0;
  logic          trigger_enable;
  logic          core_capture_done = 1'b0;
  logic          core_triggered = 1'b0;
  logic [AW-1:0] core_trigger_index = '0;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data = '0;
  logic          busy;
  logic [1:0]    seq_state;
  logic          dump_done;

  la_capture_sequencer_if #(.DATA_WIDTH(DW)) m_if ();

  la_capture_sequencer #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .POST_TRIGGER_SAMPLES(PTS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .arm(arm), .abort(abort),
    .trigger_enable(trigger_enable), .core_capture_done(core_capture_done),
    .core_triggered(core_triggered), .core_trigger_index(core_trigger_index),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .m(m_if.master),
    .busy(busy), .seq_state(seq_state), .dump_done(dump_done)
  );

  always #5 clk = ~clk;

  // Buffer model: data appears the cycle after rd_en.
  logic [DW-1:0] mem [DEPTH];
  initial for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i);
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  int n_cmp = 0, n_bad = 0;
  beat_t         exp_q[$];
  logic [AW-1:0] addr_q[$];
  int issued = 0, accepted = 0, beats = 0, first_cyc = 0, last_cyc = 0;
  int last_seen = 0, done_cnt = 0, cyc = 0;
  int ready_mode = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // m_ready driver: constant 1, or the repeating pattern 1,0,0,1.
  initial begin
    logic [3:0] pat;
    int rcnt;
    pat = 4'b1001;
    rcnt = 0;
    m_if.m_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      m_if.m_ready = (ready_mode == 0) ? 1'b1 : pat[rcnt % 4];
      rcnt++;
    end
  end

  // Monitor: compare reads and beats against the scoreboard queues.
  initial begin
    bit prev_stall, prev_abort, prev_last;
    logic [DW-1:0] prev_data;
    beat_t b;
    logic [AW-1:0] ea;
    prev_stall = 0; prev_abort = 0; prev_last = 0; prev_data = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        prev_stall = 0;
        continue;
      end
      if (prev_stall && !prev_abort) begin
        check("hold_valid", m_if.m_valid, 1);
        check("hold_data", m_if.m_data, prev_data);
        check("hold_last", m_if.m_last, prev_last);
      end
      check("outstanding_le2", (issued - accepted) <= 2, 1);
      if (rd_en) begin
        issued++;
        if (addr_q.size() > 0) begin
          ea = addr_q.pop_front();
          check("rd_addr", rd_addr, ea);
        end else check("rd_en_spurious", rd_en, 0);
      end
      if (m_if.m_valid && m_if.m_ready) begin
        accepted++;
        if (beats == 0) first_cyc = cyc;
        last_cyc = cyc;
        beats++;
        if (m_if.m_last) last_seen++;
        if (exp_q.size() > 0) begin
          b = exp_q.pop_front();
          check("m_data", m_if.m_data, b.d);
          check("m_last", m_if.m_last, b.l);
          $display("beat %0d: data=%0d last=%0d", beats, m_if.m_data, m_if.m_last);
        end else check("beat_spurious", m_if.m_valid, 0);
      end
      if (dump_done) done_cnt++;
      prev_stall = m_if.m_valid && !m_if.m_ready;
      prev_data  = m_if.m_data;
      prev_last  = m_if.m_last;
      prev_abort = abort;
    end
  end

  // Oldest sample = trigger index + 8 + 1; mem[a] = a, 16 beats, last on 16th.
  task automatic push_expect(input logic [AW-1:0] idx);
    logic [AW-1:0] a;
    beat_t b;
    for (int n = 0; n < DEPTH; n++) begin
      a = idx + AW'(PTS + 1) + AW'(n);
      addr_q.push_back(a);
      b.d = {4'b0000, a};
      b.l = (n == DEPTH - 1);
      exp_q.push_back(b);
    end
  endtask

  task automatic start_dump(input logic [AW-1:0] idx);
    beats = 0; done_cnt = 0; last_seen = 0; issued = 0; accepted = 0;
    arm = 1'b1;
    @(posedge clk); #1;
    arm = 1'b0;
    check("armed_te", trigger_enable, 1);
    check("armed_state", seq_state, 1);
    check("armed_busy", busy, 1);
    repeat (3) @(posedge clk);
    #1;
    push_expect(idx);
    core_trigger_index = idx;
    core_triggered = 1'b1;
    core_capture_done = 1'b1;
    @(posedge clk); #1;
    check("te_drop", trigger_enable, 0);
    check("readout_state", seq_state, 2);
    core_capture_done = 1'b0;
    core_triggered = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit got;
    got = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (dump_done) begin
        got = 1;
        break;
      end
    end
    check("dump_done_seen", got, 1);
  endtask

  task automatic end_checks(input bit consec);
    @(posedge clk); #1;
    check("done_width", dump_done, 0);
    check("idle_after", seq_state, 0);
    check("busy_after", busy, 0);
    check("exp_left", exp_q.size(), 0);
    check("addr_left", addr_q.size(), 0);
    check("done_count", done_cnt, 1);
    check("last_count", last_seen, 1);
    check("beat_count", beats, DEPTH);
    if (consec) check("beat_span", last_cyc - first_cyc, DEPTH - 1);
  endtask

  task automatic check_zero();
    check("z_te", trigger_enable, 0);
    check("z_rd_en", rd_en, 0);
    check("z_rd_addr", rd_addr, 0);
    check("z_valid", m_if.m_valid, 0);
    check("z_data", m_if.m_data, 0);
    check("z_last", m_if.m_last, 0);
    check("z_busy", busy, 0);
    check("z_state", seq_state, 0);
    check("z_done", dump_done, 0);
  endtask

  task automatic wait_beats(input int n, input string name);
    bit got;
    got = 0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      if (beats >= n) begin
        got = 1;
        break;
      end
    end
    check(name, got, 1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_zero();
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Case 1: trigger index 3 -> 12..15,0..11, startup latency 2 cycles.
    start_dump(4'd3);
    @(posedge clk); #1;
    check("startup_gap", m_if.m_valid, 0);
    @(posedge clk); #1;
    check("first_valid", m_if.m_valid, 1);
    check("first_data", m_if.m_data, 12);
    wait_done(100);
    end_checks(1);

    // Case 2: trigger index 7 -> start wraps to 0, stream 0..15.
    start_dump(4'd7);
    wait_done(100);
    end_checks(1);

    // Case 3: back-pressure 1,0,0,1 repeating.
    ready_mode = 1;
    start_dump(4'd3);
    wait_done(200);
    end_checks(0);
    ready_mode = 0;

    // Case 4: abort after 5 beats, then a clean re-arm.
    start_dump(4'd5);
    wait_beats(5, "abort_reach5");
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_valid", m_if.m_valid, 0);
    check("abort_state", seq_state, 0);
    check("abort_te", trigger_enable, 0);
    exp_q.delete(); addr_q.delete(); issued = 0; accepted = 0;
    repeat (4) @(posedge clk);
    #1;
    check("abort_no_done", done_cnt, 0);
    check("abort_no_last", last_seen, 0);
    start_dump(4'd3);
    wait_done(100);
    end_checks(1);

    // Case 5: arm and abort together in IDLE.
    arm = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    arm = 1'b0; abort = 1'b0;
    check("armabort_state", seq_state, 0);
    check("armabort_te", trigger_enable, 0);
    @(posedge clk); #1;
    check("armabort_te2", trigger_enable, 0);

    // Case 6: arm during READOUT is ignored.
    start_dump(4'd10);
    repeat (3) @(posedge clk);
    #1;
    arm = 1'b1;
    @(posedge clk); #1;
    arm = 1'b0;
    wait_done(100);
    end_checks(1);
    @(posedge clk); #1;
    check("no_queued_arm_state", seq_state, 0);
    check("no_queued_arm_te", trigger_enable, 0);

    // Case 7: asynchronous reset mid-READOUT, then re-arm.
    start_dump(4'd1);
    wait_beats(4, "reset_reach4");
    #2;
    rst_n = 1'b0;
    #1;
    check_zero();
    exp_q.delete(); addr_q.delete(); issued = 0; accepted = 0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    start_dump(4'd12);
    wait_done(100);
    end_checks(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
